// File: rtl/enc_quad_emulator_if.sv
// Command/output bundle for enc_quad_emulator: speed command handshake plus quadrature outputs.
// Carries enc_z only when ENC_INDEX_EN is defined.
interface enc_quad_emulator_if #(
   parameter int DATA_WIDTH = 16
);
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic signed [DATA_WIDTH-1:0] cmd_rpm;
   logic                         enc_a;
   logic                         enc_b;
   logic                         step_pulse;
   logic signed [31:0]           pos_cnt;
   logic                         busy;
`ifdef ENC_INDEX_EN
   logic                         enc_z;
`endif

   // master is the command sender / encoder consumer, slave is the emulator itself
   modport master (
      output cmd_valid,
      output cmd_rpm,
      input  cmd_ready,
      input  enc_a,
      input  enc_b,
      input  step_pulse,
      input  pos_cnt,
`ifdef ENC_INDEX_EN
      input  enc_z,
`endif
      input  busy
   );

   modport slave (
      input  cmd_valid,
      input  cmd_rpm,
      output cmd_ready,
      output enc_a,
      output enc_b,
      output step_pulse,
      output pos_cnt,
`ifdef ENC_INDEX_EN
      output enc_z,
`endif
      output busy
   );
endinterface

// File: rtl/enc_quad_emulator.sv
// Quadrature encoder emulator: turns a signed RPM command into A/B edges via a 32-bit phase accumulator.
// Optional index channel (enc_z, per-revolution edge counter) is built when ENC_INDEX_EN is defined.
module enc_quad_emulator #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int PPR         = 1040,
   parameter int DATA_WIDTH  = 16,
   parameter int DIR_GAP_CYC = 1000
) (
   input  logic              clk,
   input  logic              rst,
   enc_quad_emulator_if.slave bus
);

   // Phase increment per RPM: one accumulator wrap per quadrature edge.
   localparam logic [63:0] K_WIDE =
      ((64'(4) * 64'(PPR)) << 32) / (64'(60) * 64'(CLK_FREQ_HZ));
   localparam logic [31:0] K = K_WIDE[31:0];

   localparam logic [DATA_WIDTH-1:0] MAX_MAG  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   localparam int               GAP_W    = $clog2(DIR_GAP_CYC + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DIR_GAP_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      REV_WAIT
   } state_t;

   state_t              state;
   logic [31:0]         acc;
   logic [31:0]         inc;
   logic                dir_rev;
   logic [31:0]         pend_inc;
   logic                pend_rev;
   logic [GAP_W-1:0]    gap_cnt;
   logic                enc_a_q;
   logic                enc_b_q;
   logic                step_q;
   logic signed [31:0]  pos_q;
   logic                busy_q;
   logic                ready_q;

   logic [DATA_WIDTH-1:0] cmd_mag;
   logic                  cmd_neg;
   logic                  cmd_zero;
   logic [31:0]           cmd_inc;
   logic                  accept;
   logic [32:0]           acc_sum;
   logic                  step_now;

   always_comb begin
      cmd_neg = bus.cmd_rpm[DATA_WIDTH-1];
      cmd_mag = bus.cmd_rpm;
      if (bus.cmd_rpm == MOST_NEG) begin
         cmd_mag = MAX_MAG;
      end else if (cmd_neg) begin
         cmd_mag = -bus.cmd_rpm;
      end
      cmd_zero = (cmd_mag == '0);
      cmd_inc  = 32'(cmd_mag) * K;
      accept   = bus.cmd_valid && ready_q;
      acc_sum  = {1'b0, acc} + {1'b0, inc};
      step_now = (state == RUN) && acc_sum[32];
   end

   // A step always follows the direction in force this cycle; a command accepted
   // in the same cycle only takes effect from the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         acc      <= '0;
         inc      <= '0;
         dir_rev  <= 1'b0;
         pend_inc <= '0;
         pend_rev <= 1'b0;
         gap_cnt  <= '0;
         enc_a_q  <= 1'b0;
         enc_b_q  <= 1'b0;
         step_q   <= 1'b0;
         pos_q    <= '0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         step_q <= 1'b0;
         if (step_now) begin
            step_q <= 1'b1;
            if (dir_rev) begin
               enc_a_q <= enc_b_q;
               enc_b_q <= ~enc_a_q;
               pos_q   <= pos_q - 32'sd1;
            end else begin
               enc_a_q <= ~enc_b_q;
               enc_b_q <= enc_a_q;
               pos_q   <= pos_q + 32'sd1;
            end
         end

         case (state)
            IDLE: begin
               ready_q <= 1'b1;
               if (accept && !cmd_zero) begin
                  inc     <= cmd_inc;
                  dir_rev <= cmd_neg;
                  busy_q  <= 1'b1;
                  state   <= RUN;
               end
            end

            RUN: begin
               acc <= acc_sum[31:0];
               if (accept) begin
                  if (cmd_zero) begin
                     acc    <= '0;
                     inc    <= '0;
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end else if (cmd_neg == dir_rev) begin
                     inc <= cmd_inc;
                  end else begin
                     inc      <= '0;
                     pend_inc <= cmd_inc;
                     pend_rev <= cmd_neg;
                     gap_cnt  <= '0;
                     ready_q  <= 1'b0;
                     state    <= REV_WAIT;
                  end
               end
            end

            REV_WAIT: begin
               if (gap_cnt == GAP_LAST) begin
                  acc     <= '0;
                  inc     <= pend_inc;
                  dir_rev <= pend_rev;
                  ready_q <= 1'b1;
                  state   <= RUN;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = ready_q;
   assign bus.enc_a      = enc_a_q;
   assign bus.enc_b      = enc_b_q;
   assign bus.step_pulse = step_q;
   assign bus.pos_cnt    = pos_q;
   assign bus.busy       = busy_q;

`ifdef ENC_INDEX_EN
   localparam int               EDGES_REV = 4 * PPR;
   localparam int               REV_W     = $clog2(EDGES_REV);
   localparam logic [REV_W-1:0] REV_LAST  = REV_W'(EDGES_REV - 1);

   logic [REV_W-1:0] rev_cnt;
   logic [REV_W-1:0] rev_next;
   logic             enc_z_q;

   always_comb begin
      if (dir_rev) begin
         rev_next = (rev_cnt == '0) ? REV_LAST : rev_cnt - 1'b1;
      end else begin
         rev_next = (rev_cnt == REV_LAST) ? '0 : rev_cnt + 1'b1;
      end
   end

   // Index marks edge position zero of each revolution in either direction.
   always_ff @(posedge clk) begin
      if (rst) begin
         rev_cnt <= '0;
         enc_z_q <= 1'b1;
      end else if (step_now) begin
         rev_cnt <= rev_next;
         enc_z_q <= (rev_next == '0);
      end
   end

   assign bus.enc_z = enc_z_q;
`endif

endmodule
